// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the unified-memory port arbiter.
// Holds state encoding, request bundle, widths and a saturating helper.
package mem_port_arbiter_pkg;

  localparam int WORD_W         = 32;
  localparam int CNT_W          = 4;
  localparam int DEF_MEM_LAT    = 2;
  localparam int DEF_STARVE_MAX = 4;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BUSY_I = 2'd1,
    S_BUSY_D = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  typedef struct packed {
    logic  we;
    word_t addr;
    word_t wdata;
  } mem_req_t;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_timer.sv
// mem_lat_timer: loadable down-counter with zero flag for access latency.
// Ports: clk, rst_n, load, load_val, dec in; zero out.
module mem_lat_timer
  import mem_port_arbiter_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency memory port between fetch and data stages.
// Ports: IF req/addr/rdata/valid, MEM read/write/addr/wdata/rdata/valid, stalls, memory side.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MEM_LAT    = DEF_MEM_LAT,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic        CLK,
  input  logic        Resetb,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_valid,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [CNT_W-1:0] LAT_V  = CNT_W'(MEM_LAT);
  localparam logic [CNT_W-1:0] SMAX_V = CNT_W'(STARVE_MAX);

  state_t           state;
  state_t           state_nxt;
  mem_req_t         req_q;
  logic [CNT_W-1:0] starve_cnt;
  logic             d_req;
  logic             grant_d;
  logic             grant_i;
  logic             finish;
  logic             busy;
  logic             lat_zero;

  assign d_req = d_read | d_write;
  assign busy  = (state == S_BUSY_I) || (state == S_BUSY_D);

  always_ff @(posedge CLK or negedge Resetb) begin
    if (!Resetb) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant_d   = 1'b0;
    grant_i   = 1'b0;
    finish    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (d_req && (starve_cnt < SMAX_V || !if_req)) begin
          grant_d   = 1'b1;
          state_nxt = S_BUSY_D;
        end else if (if_req) begin
          grant_i   = 1'b1;
          state_nxt = S_BUSY_I;
        end
      end
      S_BUSY_I, S_BUSY_D: begin
        if (lat_zero) begin
          finish    = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        // Requester still shows the finished request; do not resample.
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  mem_lat_timer #(
    .W(CNT_W)
  ) u_timer (
    .clk      (CLK),
    .rst_n    (Resetb),
    .load     (grant_d | grant_i),
    .load_val (LAT_V),
    .dec      (busy),
    .zero     (lat_zero)
  );

  always_ff @(posedge CLK or negedge Resetb) begin
    if (!Resetb) begin
      mem_en     <= 1'b0;
      req_q      <= '0;
      if_rdata   <= '0;
      d_rdata    <= '0;
      if_valid   <= 1'b0;
      d_valid    <= 1'b0;
      starve_cnt <= '0;
    end else begin
      mem_en   <= grant_d | grant_i;
      if_valid <= finish && (state == S_BUSY_I);
      d_valid  <= finish && (state == S_BUSY_D);
      if (grant_d) begin
        // Read+write together is performed as a write.
        req_q <= '{we: d_write, addr: d_addr, wdata: d_wdata};
      end else if (grant_i) begin
        req_q <= '{we: 1'b0, addr: if_addr, wdata: '0};
      end
      if (finish && state == S_BUSY_I) begin
        if_rdata <= mem_rdata;
      end
      if (finish && state == S_BUSY_D && !req_q.we) begin
        d_rdata <= mem_rdata;
      end
      if (grant_i) begin
        starve_cnt <= '0;
      end else if (grant_d && if_req) begin
        starve_cnt <= sat_inc(starve_cnt);
      end else if (state == S_IDLE && !if_req) begin
        starve_cnt <= '0;
      end
    end
  end

  assign mem_we    = req_q.we;
  assign mem_addr  = req_q.addr;
  assign mem_wdata = req_q.wdata;

  assign stall_if  = if_req & ~if_valid;
  assign stall_mem = d_req & ~d_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random traffic.
// Random phase predicts grants from arbitration rules and access timing arithmetic.
module tb_mem_port_arbiter;

  localparam int L    = 2;
  localparam int SMAX = 4;

  logic        CLK = 1'b0;
  logic        Resetb;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        d_read;
  logic        d_write;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic        stall_if;
  logic        stall_mem;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [31:0] exp_d_rdata;
  logic [31:0] exp_if_rdata;

  logic [31:0] mem [logic [31:0]];
  bit          pend = 0;
  int          due = 0;
  logic [31:0] pdata;

  mem_port_arbiter #(
    .MEM_LAT(L),
    .STARVE_MAX(SMAX)
  ) dut (
    .CLK(CLK), .Resetb(Resetb),
    .if_req(if_req), .if_addr(if_addr),
    .if_rdata(if_rdata), .if_valid(if_valid),
    .d_read(d_read), .d_write(d_write),
    .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'h5A5A_1234;
  endfunction

  // Memory macro: read data valid only in the cycle L after mem_en.
  always @(negedge CLK) begin
    if (mem_en) begin
      if (mem_we) begin
        mem[mem_addr] = mem_wdata;
      end else begin
        pend  = 1;
        due   = cyc + L;
        pdata = mem_read(mem_addr);
      end
    end
    if (pend && due == cyc) begin
      mem_rdata = pdata;
      pend = 0;
    end else begin
      mem_rdata = $urandom;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    if_req  = 0;
    if_addr = 0;
    d_read  = 0;
    d_write = 0;
    d_addr  = 0;
    d_wdata = 0;
  endtask

  task automatic test_reset();
    Resetb = 0;
    clear_inputs();
    repeat (2) @(negedge CLK);
    checks++;
    if ({if_rdata, if_valid, d_rdata, d_valid, stall_if, stall_mem,
         mem_en, mem_we, mem_addr, mem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: nonzero output mem_en=%b if_valid=%b d_valid=%b mem_addr=%h want all 0",
               mem_en, if_valid, d_valid, mem_addr);
    end
    tick();
    Resetb = 1;
    exp_d_rdata  = 0;
    exp_if_rdata = 0;
    repeat (2) @(negedge CLK);
    checks++;
    if (mem_en !== 1'b0 || if_valid !== 1'b0 || d_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: mem_en=%b if_valid=%b d_valid=%b want 0 0 0",
               mem_en, if_valid, d_valid);
    end
  endtask

  task automatic test_fetch();
    mem[32'h40] = 32'h8C01_0004;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (k == 0) begin
        if_req  = 1;
        if_addr = 32'h40;
      end
      if (k == 5) if_req = 0;
      @(negedge CLK);
      checks++;
      if (mem_en !== (k == 1)) begin
        errors++;
        $display("FAIL fetch_mem_en k=%0d: got %b want %b", k, mem_en, k == 1);
      end
      if (k == 1) begin
        checks++;
        if ({mem_we, mem_addr} !== {1'b0, 32'h40}) begin
          errors++;
          $display("FAIL fetch_mem_addr: we=%b addr=%h want 0 00000040", mem_we, mem_addr);
        end
      end
      checks++;
      if (if_valid !== (k == 4)) begin
        errors++;
        $display("FAIL fetch_valid k=%0d: got %b want %b", k, if_valid, k == 4);
      end
      checks++;
      if (stall_if !== (k < 4)) begin
        errors++;
        $display("FAIL fetch_stall k=%0d: got %b want %b", k, stall_if, k < 4);
      end
      if (k == 4) begin
        checks++;
        if (if_rdata !== 32'h8C01_0004) begin
          errors++;
          $display("FAIL fetch_rdata: got %h want 8c010004", if_rdata);
        end
      end
    end
    exp_if_rdata = 32'h8C01_0004;
    repeat (2) tick();
  endtask

  task automatic test_store();
    for (int k = 0; k < 6; k++) begin
      tick();
      if (k == 0) begin
        d_write = 1;
        d_addr  = 32'h100;
        d_wdata = 32'hDEAD_BEEF;
      end
      if (k == 5) d_write = 0;
      @(negedge CLK);
      checks++;
      if (mem_en !== (k == 1)) begin
        errors++;
        $display("FAIL store_mem_en k=%0d: got %b want %b", k, mem_en, k == 1);
      end
      if (k == 1) begin
        checks++;
        if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 32'h100, 32'hDEAD_BEEF}) begin
          errors++;
          $display("FAIL store_mem_bus: we=%b addr=%h wdata=%h want 1 00000100 deadbeef",
                   mem_we, mem_addr, mem_wdata);
        end
      end
      checks++;
      if (d_valid !== (k == 4)) begin
        errors++;
        $display("FAIL store_valid k=%0d: got %b want %b", k, d_valid, k == 4);
      end
      checks++;
      if (stall_mem !== (k < 4)) begin
        errors++;
        $display("FAIL store_stall k=%0d: got %b want %b", k, stall_mem, k < 4);
      end
      checks++;
      if (d_rdata !== exp_d_rdata) begin
        errors++;
        $display("FAIL store_rdata_hold k=%0d: got %h want %h", k, d_rdata, exp_d_rdata);
      end
    end
    repeat (2) tick();
  endtask

  task automatic test_priority();
    mem[32'h200] = 32'h1111_2222;
    mem[32'h44]  = 32'h3333_4444;
    for (int k = 0; k < 11; k++) begin
      tick();
      if (k == 0) begin
        if_req  = 1;
        if_addr = 32'h44;
        d_read  = 1;
        d_addr  = 32'h200;
      end
      if (k == 5) d_read = 0;
      if (k == 10) if_req = 0;
      @(negedge CLK);
      checks++;
      if (mem_en !== (k == 1 || k == 6)) begin
        errors++;
        $display("FAIL prio_mem_en k=%0d: got %b want %b", k, mem_en, k == 1 || k == 6);
      end
      if (k == 1 || k == 6) begin
        checks++;
        if (mem_addr !== ((k == 1) ? 32'h200 : 32'h44)) begin
          errors++;
          $display("FAIL prio_order k=%0d: addr %h want %h", k, mem_addr,
                   (k == 1) ? 32'h200 : 32'h44);
        end
      end
      checks++;
      if ({d_valid, if_valid} !== {k == 4, k == 9}) begin
        errors++;
        $display("FAIL prio_valids k=%0d: d=%b i=%b want %b %b", k, d_valid, if_valid,
                 k == 4, k == 9);
      end
      checks++;
      if (stall_if !== (k < 9)) begin
        errors++;
        $display("FAIL prio_stall_if k=%0d: got %b want %b", k, stall_if, k < 9);
      end
      if (k == 4) begin
        checks++;
        if (d_rdata !== 32'h1111_2222) begin
          errors++;
          $display("FAIL prio_d_rdata: got %h want 11112222", d_rdata);
        end
      end
      if (k == 9) begin
        checks++;
        if (if_rdata !== 32'h3333_4444) begin
          errors++;
          $display("FAIL prio_if_rdata: got %h want 33334444", if_rdata);
        end
      end
    end
    exp_d_rdata  = 32'h1111_2222;
    exp_if_rdata = 32'h3333_4444;
    repeat (2) tick();
  endtask

  task automatic test_starvation();
    logic e_en;
    logic e_dv;
    for (int k = 0; k < 32; k++) begin
      tick();
      if (k == 0) begin
        if_req  = 1;
        if_addr = 32'h80;
        d_read  = 1;
        d_addr  = 32'h300;
      end
      if (k == 27) begin
        if_req = 0;
        d_read = 0;
      end
      @(negedge CLK);
      e_en = (k % 5 == 1) && (k <= 26);
      e_dv = (k % 5 == 4) && (k != 24) && (k <= 29);
      checks++;
      if (mem_en !== e_en) begin
        errors++;
        $display("FAIL starve_mem_en k=%0d: got %b want %b", k, mem_en, e_en);
      end
      if (e_en) begin
        checks++;
        if (mem_addr !== ((k == 21) ? 32'h80 : 32'h300)) begin
          errors++;
          $display("FAIL starve_grant k=%0d: addr %h want %h", k, mem_addr,
                   (k == 21) ? 32'h80 : 32'h300);
        end
      end
      checks++;
      if ({d_valid, if_valid} !== {e_dv, k == 24}) begin
        errors++;
        $display("FAIL starve_valids k=%0d: d=%b i=%b want %b %b", k, d_valid, if_valid,
                 e_dv, k == 24);
      end
      if (e_dv) begin
        checks++;
        if (d_rdata !== mem_read(32'h300)) begin
          errors++;
          $display("FAIL starve_d_rdata k=%0d: got %h want %h", k, d_rdata, mem_read(32'h300));
        end
      end
    end
    exp_d_rdata  = mem_read(32'h300);
    exp_if_rdata = mem_read(32'h80);
    repeat (2) tick();
  endtask

  task automatic test_rw_both();
    for (int k = 0; k < 6; k++) begin
      tick();
      if (k == 0) begin
        d_read  = 1;
        d_write = 1;
        d_addr  = 32'h104;
        d_wdata = 32'h1234_5678;
      end
      if (k == 5) begin
        d_read  = 0;
        d_write = 0;
      end
      @(negedge CLK);
      checks++;
      if (mem_en !== (k == 1)) begin
        errors++;
        $display("FAIL rw_mem_en k=%0d: got %b want %b", k, mem_en, k == 1);
      end
      if (k == 1) begin
        checks++;
        if ({mem_we, mem_wdata} !== {1'b1, 32'h1234_5678}) begin
          errors++;
          $display("FAIL rw_is_write: we=%b wdata=%h want 1 12345678", mem_we, mem_wdata);
        end
      end
      checks++;
      if (d_valid !== (k == 4)) begin
        errors++;
        $display("FAIL rw_valid k=%0d: got %b want %b", k, d_valid, k == 4);
      end
      checks++;
      if (d_rdata !== exp_d_rdata) begin
        errors++;
        $display("FAIL rw_rdata_hold k=%0d: got %h want %h", k, d_rdata, exp_d_rdata);
      end
    end
    repeat (2) tick();
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 13; k++) begin
      tick();
      if (k == 0) begin
        d_read = 1;
        d_addr = 32'h108;
      end
      if (k == 2) begin
        Resetb = 0;
        d_read = 0;
        exp_d_rdata  = 0;
        exp_if_rdata = 0;
        #1;
        checks++;
        if ({if_rdata, if_valid, d_rdata, d_valid, stall_if, stall_mem,
             mem_en, mem_we, mem_addr, mem_wdata} !== '0) begin
          errors++;
          $display("FAIL midreset_outputs: mem_en=%b we=%b addr=%h d_rdata=%h want all 0",
                   mem_en, mem_we, mem_addr, d_rdata);
        end
      end
      if (k == 4) Resetb = 1;
      if (k == 6) begin
        if_req  = 1;
        if_addr = 32'h40;
      end
      if (k == 11) if_req = 0;
      @(negedge CLK);
      checks++;
      if (d_valid !== 1'b0) begin
        errors++;
        $display("FAIL midreset_no_dvalid k=%0d: got %b want 0", k, d_valid);
      end
      checks++;
      if (mem_en !== (k == 1 || k == 7)) begin
        errors++;
        $display("FAIL midreset_mem_en k=%0d: got %b want %b", k, mem_en, k == 1 || k == 7);
      end
      checks++;
      if (if_valid !== (k == 10)) begin
        errors++;
        $display("FAIL midreset_if_valid k=%0d: got %b want %b", k, if_valid, k == 10);
      end
      if (k >= 2) begin
        checks++;
        if (d_rdata !== 32'h0) begin
          errors++;
          $display("FAIL midreset_d_rdata k=%0d: got %h want 0", k, d_rdata);
        end
      end
      if (k == 10) begin
        checks++;
        if (if_rdata !== mem_read(32'h40)) begin
          errors++;
          $display("FAIL midreset_fetch_rdata: got %h want %h", if_rdata, mem_read(32'h40));
        end
      end
    end
    exp_if_rdata = mem_read(32'h40);
    repeat (2) tick();
  endtask

  task automatic test_random();
    int          next_free;
    int          en_c;
    int          val_c;
    int          starve;
    int          r;
    bit          own_i;
    bit          granted;
    bit          seen_iv;
    bit          seen_dv;
    logic        e_en;
    logic        e_iv;
    logic        e_dv;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_data;
    next_free = 0;
    en_c      = -1;
    val_c     = -1;
    starve    = 0;
    own_i     = 0;
    seen_iv   = 0;
    seen_dv   = 0;
    m_we      = 0;
    m_addr    = 0;
    m_wdata   = 0;
    m_data    = 0;
    Resetb = 0;
    clear_inputs();
    tick();
    for (int c = 0; c < 600; c++) begin
      tick();
      if (c == 0) begin
        Resetb       = 1;
        exp_d_rdata  = 0;
        exp_if_rdata = 0;
      end
      if (seen_iv) if_req = 0;
      if (!if_req && $urandom_range(0, 3) == 0) begin
        if_req  = 1;
        if_addr = 32'($urandom_range(0, 15) * 4);
      end
      if (seen_dv) begin
        d_read  = 0;
        d_write = 0;
      end
      if (!(d_read | d_write) && $urandom_range(0, 2) == 0) begin
        r       = $urandom_range(0, 7);
        d_read  = (r < 4) || (r == 7);
        d_write = (r >= 4);
        d_addr  = 32'($urandom_range(0, 15) * 4);
        d_wdata = $urandom;
      end
      @(negedge CLK);
      e_en = (c == en_c);
      e_iv = (c == val_c) && own_i;
      e_dv = (c == val_c) && !own_i;
      seen_iv = e_iv;
      seen_dv = e_dv;
      if (e_iv) exp_if_rdata = m_data;
      if (e_dv && !m_we) exp_d_rdata = m_data;
      checks++;
      if ({mem_en, if_valid, d_valid} !== {e_en, e_iv, e_dv}) begin
        errors++;
        $display("FAIL rand_strobes c=%0d: en/iv/dv=%b%b%b want %b%b%b", c,
                 mem_en, if_valid, d_valid, e_en, e_iv, e_dv);
      end
      checks++;
      if ({if_rdata, d_rdata} !== {exp_if_rdata, exp_d_rdata}) begin
        errors++;
        $display("FAIL rand_rdata c=%0d: if=%h d=%h want %h %h", c, if_rdata, d_rdata,
                 exp_if_rdata, exp_d_rdata);
      end
      checks++;
      if ({stall_if, stall_mem} !== {if_req & ~e_iv, (d_read | d_write) & ~e_dv}) begin
        errors++;
        $display("FAIL rand_stall c=%0d: if=%b mem=%b want %b %b", c, stall_if, stall_mem,
                 if_req & ~e_iv, (d_read | d_write) & ~e_dv);
      end
      if (e_en) begin
        checks++;
        if ({mem_we, mem_addr} !== {m_we, m_addr} || (m_we && mem_wdata !== m_wdata)) begin
          errors++;
          $display("FAIL rand_mem_bus c=%0d: we=%b addr=%h wdata=%h want %b %h %h", c,
                   mem_we, mem_addr, mem_wdata, m_we, m_addr, m_wdata);
        end
      end
      if (c >= next_free) begin
        granted = 0;
        if (!if_req) starve = 0;
        if ((d_read | d_write) && (starve < SMAX || !if_req)) begin
          granted = 1;
          own_i   = 0;
          m_we    = d_write;
          m_addr  = d_addr;
          m_wdata = d_wdata;
          if (if_req && starve < 15) starve++;
        end else if (if_req) begin
          granted = 1;
          own_i   = 1;
          m_we    = 0;
          m_addr  = if_addr;
          starve  = 0;
        end
        if (granted) begin
          en_c      = c + 1;
          val_c     = c + 2 + L;
          next_free = c + 3 + L;
          m_data    = m_we ? 32'h0 : mem_read(m_addr);
        end
      end
    end
    clear_inputs();
    repeat (8) tick();
  endtask

  initial begin
    clear_inputs();
    exp_d_rdata  = 0;
    exp_if_rdata = 0;
    test_reset();
    test_fetch();
    test_store();
    test_priority();
    test_starvation();
    test_rw_both();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
